// File: rtl/sweep_pkg.sv
// sweep_pkg: shared types and constants for the exhaustive stimulus/capture engine.
package sweep_pkg;
    typedef enum logic [2:0] {IDLE, DRIVE, SETTLE, SAMPLE, EMIT, DONE} state_t;
    localparam logic [1:0] MODE_BIN = 2'd0;
    localparam logic [1:0] MODE_GRAY = 2'd1;
    localparam logic [1:0] MODE_DOWN = 2'd2;
    localparam logic [15:0] DEFAULT_SIG_POLY = 16'h1021;
endpackage

// File: rtl/sweep_misr.sv
// sweep_misr: multiple-input signature register, seeded to all-ones on reset or clear.
module sweep_misr import sweep_pkg::*; #(
    parameter int SIG_WIDTH = 16,
    parameter logic [SIG_WIDTH-1:0] SIG_POLY = SIG_WIDTH'(DEFAULT_SIG_POLY)
) (
    input  logic                 CK,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [SIG_WIDTH-1:0] data,
    output logic [SIG_WIDTH-1:0] signature
);
    always_ff @(posedge CK or posedge reset) begin
        if (reset)
            signature <= '1;
        else if (clear)
            signature <= '1;
        else if (enable)
            signature <= {signature[SIG_WIDTH-2:0], 1'b0} ^ (signature[SIG_WIDTH-1] ? SIG_POLY : '0) ^ data;
    end
endmodule

// File: rtl/sweep_stim_capture.sv
// sweep_stim_capture: drives every N_WIDTH-bit vector, samples the response after a settle
// time, streams (stimulus, response) records with backpressure and compacts them in a MISR.
module sweep_stim_capture import sweep_pkg::*; #(
    parameter int N_WIDTH = 6,
    parameter int OUT_WIDTH = 1,
    parameter int SETTLE_CYCLES = 1,
    parameter int SIG_WIDTH = 16,
    parameter logic [SIG_WIDTH-1:0] SIG_POLY = SIG_WIDTH'(DEFAULT_SIG_POLY)
) (
    input  logic                 CK,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [1:0]           mode,
    output logic [N_WIDTH-1:0]   stim_out,
    input  logic [OUT_WIDTH-1:0] dut_resp,
    output logic                 rec_valid,
    input  logic                 rec_ready,
    output logic [N_WIDTH-1:0]   rec_stim,
    output logic [OUT_WIDTH-1:0] rec_resp,
    output logic                 busy,
    output logic                 done,
    output logic [N_WIDTH:0]     vec_count,
    output logic [SIG_WIDTH-1:0] signature
);
    localparam int CW = $clog2(SETTLE_CYCLES) + 1;
    localparam int VW = N_WIDTH + 1;
    state_t state, state_next;
    logic [1:0] mode_q;
    logic [N_WIDTH-1:0] idx, mapped;
    logic [CW-1:0] cnt;
    logic go, settled, last, handshake, sample;
    always_ff @(posedge CK or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end
    always_comb begin
        go = start && (state == IDLE || (state == DONE && !abort));
        settled = cnt == CW'(SETTLE_CYCLES - 1);
        last = &idx;
        handshake = state == EMIT && rec_ready && !abort;
        sample = state == SAMPLE && !abort;
        mapped = mode_q == MODE_GRAY ? idx ^ (idx >> 1) : mode_q == MODE_DOWN ? ~idx : idx;
        busy = state != IDLE && state != DONE;
        done = state == DONE;
        rec_valid = state == EMIT;
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = DRIVE;
            DRIVE:      state_next = SETTLE;
            SETTLE:     if (settled) state_next = SAMPLE;
            SAMPLE:     state_next = EMIT;
            EMIT:       if (rec_ready) state_next = last ? DONE : DRIVE;
            default:    state_next = IDLE;
        endcase
        // abort wins over start and over a pending handshake
        if (abort && state != IDLE) state_next = IDLE;
    end
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            mode_q <= '0;
            idx <= '0;
            cnt <= '0;
            stim_out <= '0;
            rec_stim <= '0;
            rec_resp <= '0;
            vec_count <= '0;
        end else begin
            if (go) begin
                mode_q <= mode;
                idx <= '0;
                vec_count <= '0;
            end
            if (state == DRIVE) begin
                stim_out <= mapped;
                cnt <= '0;
            end
            if (state == SETTLE) cnt <= cnt + CW'(1);
            if (sample) begin
                rec_stim <= stim_out;
                rec_resp <= dut_resp;
            end
            if (handshake) begin
                vec_count <= vec_count + VW'(1);
                idx <= idx + N_WIDTH'(1);
            end
        end
    end
    sweep_misr #(.SIG_WIDTH(SIG_WIDTH), .SIG_POLY(SIG_POLY)) u_misr (
        .CK(CK),
        .reset(reset),
        .clear(go),
        .enable(sample),
        .data(SIG_WIDTH'({dut_resp, stim_out})),
        .signature(signature)
    );
endmodule
